// File: rtl/card_shoe.sv
// card_shoe: multi-deck card shoe with an unbiased Fisher-Yates shuffle.
//
// Loads NUM_DECKS standard 52-card decks, shuffles them with a Fisher-Yates pass
// driven by a free-running 32-bit LFSR, then deals one card per valid/ready handshake.
// The pass uses masked rejection sampling so every swap index is equally likely.
// Cards are encoded as {suit[1:0], rank[3:0]} with rank 2..14 (14 = ace).
//
// Ports:
//   clk             clock
//   rst             asynchronous active-low reset
//   new_hand_i      level request to reload and reshuffle (wins over everything)
//   card_ready_i    consumer accepts the presented card this cycle
//   card_valid_o    card_o holds a dealable card
//   card_o          card at the top of the shoe, 0 when card_valid_o is low
//   shuffled_o      shoe loaded and shuffled (ready to deal or dealt out)
//   remaining_o     undealt cards, 0 unless shuffled_o
//   empty_o         all cards dealt
//   reshuffle_due_o shuffled_o && remaining_o <= PENETRATION (cut card reached)
module card_shoe #(
    parameter int unsigned NUM_DECKS   = 1,
    parameter logic [31:0] SEED        = 32'hEB53FD15,
    parameter int unsigned PENETRATION = 13,
    localparam int unsigned N          = 52 * NUM_DECKS,
    localparam int unsigned IDX_W      = $clog2(N),
    localparam int unsigned CNT_W      = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_hand_i,
    input  logic             card_ready_i,
    output logic             card_valid_o,
    output logic [5:0]       card_o,
    output logic             shuffled_o,
    output logic [CNT_W-1:0] remaining_o,
    output logic             empty_o,
    output logic             reshuffle_due_o
);

    localparam logic [IDX_W-1:0] ILast   = IDX_W'(N - 1);
    localparam logic [IDX_W:0]   DpLast  = (IDX_W + 1)'(N - 1);
    localparam logic [CNT_W-1:0] NumCard = CNT_W'(N);
    localparam logic [CNT_W-1:0] PenThr  = CNT_W'(PENETRATION);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StShuffle,
        StReady,
        StEmpty
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [IDX_W:0]   dp_q, dp_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] k_q, k_d;
    // Rank/suit of the card written at k; counted alongside k to avoid a mod-52 divider.
    logic [3:0]       rank_q, rank_d;
    logic [1:0]       suit_q, suit_d;

    logic [5:0]       shoe_q [N];

    logic [IDX_W-1:0] mask;
    logic [IDX_W-1:0] j_cand;
    logic             init_we;
    logic             swap_en;
    logic [5:0]       init_card;

    // Free-running Fibonacci LFSR, taps 31/30/12/7.
    assign lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[30] ^ lfsr_q[12] ^ lfsr_q[7]};

    // Smallest all-ones mask covering i; candidates above i are rejected, which
    // keeps the accepted j uniform over 0..i with acceptance probability >= 1/2.
    always_comb begin
        mask = i_q;
        for (int s = 1; s < IDX_W; s++) begin
            mask = mask | (i_q >> s);
        end
        j_cand = lfsr_q[IDX_W-1:0] & mask;
    end

    assign init_card = {suit_q, rank_q + 4'd2};

    always_comb begin
        state_d = state_q;
        dp_d    = dp_q;
        i_d     = i_q;
        k_d     = k_q;
        rank_d  = rank_q;
        suit_d  = suit_q;
        init_we = 1'b0;
        swap_en = 1'b0;

        if (new_hand_i) begin
            // Reload request overrides any handshake in the same cycle.
            state_d = StInit;
            k_d     = '0;
            dp_d    = '0;
            rank_d  = '0;
            suit_d  = '0;
        end else begin
            case (state_q)
                StIdle: ;
                StInit: begin
                    init_we = 1'b1;
                    if (rank_q == 4'd12) begin
                        rank_d = '0;
                        suit_d = suit_q + 2'd1;
                    end else begin
                        rank_d = rank_q + 4'd1;
                    end
                    if (k_q == ILast) begin
                        state_d = StShuffle;
                        i_d     = ILast;
                    end else begin
                        k_d = k_q + IDX_W'(1);
                    end
                end
                StShuffle: begin
                    if (j_cand <= i_q) begin
                        swap_en = 1'b1;
                        i_d     = i_q - IDX_W'(1);
                        if (i_q == IDX_W'(1)) begin
                            state_d = StReady;
                        end
                    end
                end
                StReady: begin
                    if (card_ready_i) begin
                        dp_d = dp_q + (IDX_W + 1)'(1);
                        if (dp_q == DpLast) begin
                            state_d = StEmpty;
                        end
                    end
                end
                StEmpty: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            lfsr_q  <= SEED;
            dp_q    <= '0;
            i_q     <= ILast;
            k_q     <= '0;
            rank_q  <= '0;
            suit_q  <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            dp_q    <= dp_d;
            i_q     <= i_d;
            k_q     <= k_d;
            rank_q  <= rank_d;
            suit_q  <= suit_d;
        end
    end

    // Card storage needs no reset: it is always rewritten before it is read.
    always_ff @(posedge clk) begin
        if (init_we) begin
            shoe_q[k_q] <= init_card;
        end
        if (swap_en) begin
            shoe_q[i_q]    <= shoe_q[j_cand];
            shoe_q[j_cand] <= shoe_q[i_q];
        end
    end

    always_comb begin
        card_valid_o    = (state_q == StReady);
        shuffled_o      = (state_q == StReady) || (state_q == StEmpty);
        empty_o         = (state_q == StEmpty);
        card_o          = card_valid_o ? shoe_q[dp_q[IDX_W-1:0]] : 6'd0;
        remaining_o     = shuffled_o ? (NumCard - CNT_W'(dp_q)) : '0;
        reshuffle_due_o = shuffled_o && (remaining_o <= PenThr);
    end

endmodule

// File: tb/tb_card_shoe.sv
module tb_card_shoe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Single-deck shoe
    logic       rst1, nh1, rdy1, valid1, shuf1, empty1, due1;
    logic [5:0] card1, rem1;
    // Two-deck shoe
    logic       rst2, nh2, rdy2, valid2, shuf2, empty2, due2;
    logic [5:0] card2;
    logic [6:0] rem2;

    card_shoe #(.NUM_DECKS(1)) dut1 (
        .clk             (clk),
        .rst             (rst1),
        .new_hand_i      (nh1),
        .card_ready_i    (rdy1),
        .card_valid_o    (valid1),
        .card_o          (card1),
        .shuffled_o      (shuf1),
        .remaining_o     (rem1),
        .empty_o         (empty1),
        .reshuffle_due_o (due1)
    );

    card_shoe #(.NUM_DECKS(2)) dut2 (
        .clk             (clk),
        .rst             (rst2),
        .new_hand_i      (nh2),
        .card_ready_i    (rdy2),
        .card_valid_o    (valid2),
        .card_o          (card2),
        .shuffled_o      (shuf2),
        .remaining_o     (rem2),
        .empty_o         (empty2),
        .reshuffle_due_o (due2)
    );

    int n_cmp = 0;
    int n_err = 0;
    int hist[64];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Number of encodings whose dealt count differs from copies-per-card.
    function automatic int hist_bad(input int copies);
        int bad;
        int rank;
        bad = 0;
        for (int e = 0; e < 64; e++) begin
            rank = e % 16;
            if (hist[e] != ((rank >= 2 && rank <= 14) ? copies : 0)) bad++;
        end
        return bad;
    endfunction

    task automatic wait_shuf1(output int cyc);
        cyc = 0;
        while (!shuf1 && cyc < 3000) begin
            tick();
            cyc++;
        end
        check_eq("shuf1_timeout", 32'(shuf1), 32'd1);
    endtask

    // Full single-deck deal; toggle selects ready pattern 1,0,0,1 instead of always-1.
    task automatic deal1(input bit toggle);
        int         dealt;
        int         cyc;
        bit         r;
        bit         prev_lo;
        logic [5:0] prev_card;
        dealt     = 0;
        cyc       = 0;
        prev_lo   = 1'b0;
        prev_card = '0;
        for (int e = 0; e < 64; e++) hist[e] = 0;
        while (!empty1 && cyc < 400) begin
            r    = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            rdy1 = r;
            check_eq("deal_rem", 32'(rem1), 32'(52 - dealt));
            check_eq("deal_valid", 32'(valid1), 32'd1);
            check_eq("deal_due", 32'(due1), 32'((52 - dealt) <= 13));
            if (prev_lo) check_eq("frozen_card", 32'(card1), 32'(prev_card));
            if (r) begin
                hist[card1]++;
                dealt++;
            end
            prev_lo   = !r;
            prev_card = card1;
            tick();
            cyc++;
        end
        rdy1 = 1'b0;
        check_eq("deal_count", 32'(dealt), 32'd52);
        check_eq("end_empty", 32'(empty1), 32'd1);
        check_eq("end_valid", 32'(valid1), 32'd0);
        check_eq("end_card", 32'(card1), 32'd0);
        check_eq("end_rem", 32'(rem1), 32'd0);
        check_eq("end_due", 32'(due1), 32'd1);
        check_eq("end_shuf", 32'(shuf1), 32'd1);
        check_eq("multiset1", 32'(hist_bad(1)), 32'd0);
    endtask

    initial begin
        int cyc;
        int dealt;
        bit seen;
        rst1 = 1'b0; nh1 = 1'b0; rdy1 = 1'b0;
        rst2 = 1'b0; nh2 = 1'b0; rdy2 = 1'b0;

        // Reset state
        repeat (3) tick();
        check_eq("rst_valid", 32'(valid1), 32'd0);
        check_eq("rst_card", 32'(card1), 32'd0);
        check_eq("rst_shuf", 32'(shuf1), 32'd0);
        check_eq("rst_rem", 32'(rem1), 32'd0);
        check_eq("rst_empty", 32'(empty1), 32'd0);
        check_eq("rst_due", 32'(due1), 32'd0);

        // Idle: nothing happens without new_hand
        rst1 = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (valid1 || shuf1 || empty1 || due1 || rem1 != 0 || card1 != 0) seen = 1'b1;
        end
        check_eq("idle_quiet", 32'(seen), 32'd0);

        // Load, shuffle, full deal with ready held high
        nh1 = 1'b1;
        tick();
        nh1 = 1'b0;
        check_eq("nh_shuf", 32'(shuf1), 32'd0);
        check_eq("nh_valid", 32'(valid1), 32'd0);
        wait_shuf1(cyc);
        check_eq("shuffle_min_time", 32'(cyc >= 103), 32'd1);
        check_eq("first_rem", 32'(rem1), 32'd52);
        check_eq("first_valid", 32'(valid1), 32'd1);
        deal1(1'b0);

        // Reshuffle from EMPTY, deal with ready pattern 1,0,0,1
        nh1 = 1'b1;
        tick();
        nh1 = 1'b0;
        check_eq("reload_empty", 32'(empty1), 32'd0);
        check_eq("reload_due", 32'(due1), 32'd0);
        wait_shuf1(cyc);
        deal1(1'b1);

        // new_hand together with card_ready mid-deal
        nh1 = 1'b1;
        tick();
        nh1 = 1'b0;
        wait_shuf1(cyc);
        rdy1 = 1'b1;
        repeat (10) tick();
        check_eq("ten_dealt_rem", 32'(rem1), 32'd42);
        nh1 = 1'b1;
        tick();
        nh1  = 1'b0;
        rdy1 = 1'b0;
        check_eq("abort_shuf", 32'(shuf1), 32'd0);
        check_eq("abort_valid", 32'(valid1), 32'd0);
        check_eq("abort_rem", 32'(rem1), 32'd0);
        check_eq("abort_empty", 32'(empty1), 32'd0);
        check_eq("abort_due", 32'(due1), 32'd0);
        wait_shuf1(cyc);
        check_eq("abort_reload_rem", 32'(rem1), 32'd52);
        deal1(1'b0);

        // Two decks: reset mid-shuffle, then a clean load and full deal
        rst2 = 1'b1;
        tick();
        nh2 = 1'b1;
        tick();
        nh2 = 1'b0;
        repeat (130) tick();  // INIT is 104 cycles, SHUFFLE at least 103
        check_eq("d2_midshuf", 32'(shuf2), 32'd0);
        #2 rst2 = 1'b0;
        #1;
        check_eq("d2_rst_shuf", 32'(shuf2), 32'd0);
        check_eq("d2_rst_valid", 32'(valid2), 32'd0);
        check_eq("d2_rst_rem", 32'(rem2), 32'd0);
        check_eq("d2_rst_empty", 32'(empty2), 32'd0);
        check_eq("d2_rst_due", 32'(due2), 32'd0);
        tick();
        rst2 = 1'b1;
        tick();
        nh2 = 1'b1;
        tick();
        nh2 = 1'b0;
        cyc = 0;
        while (!shuf2 && cyc < 5000) begin
            tick();
            cyc++;
        end
        check_eq("d2_shuf_timeout", 32'(shuf2), 32'd1);
        check_eq("d2_shuffle_min_time", 32'(cyc >= 207), 32'd1);
        check_eq("d2_first_rem", 32'(rem2), 32'd104);
        for (int e = 0; e < 64; e++) hist[e] = 0;
        dealt = 0;
        rdy2  = 1'b1;
        cyc   = 0;
        while (!empty2 && cyc < 300) begin
            check_eq("d2_rem", 32'(rem2), 32'(104 - dealt));
            check_eq("d2_due", 32'(due2), 32'((104 - dealt) <= 13));
            hist[card2]++;
            dealt++;
            tick();
            cyc++;
        end
        rdy2 = 1'b0;
        check_eq("d2_count", 32'(dealt), 32'd104);
        check_eq("d2_empty", 32'(empty2), 32'd1);
        check_eq("d2_valid", 32'(valid2), 32'd0);
        check_eq("d2_rem_end", 32'(rem2), 32'd0);
        check_eq("multiset2", 32'(hist_bad(2)), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
